// File: rtl/pc_sequencer_if.sv
// Request/status bundle between an instruction-fetch controller and pc_sequencer.
// The master drives the control requests; the slave (the sequencer) returns PC and status.
interface pc_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 9
);
  logic              stall;
  logic              branch;
  logic [2:0]        cond;
  logic              Z;
  logic              N;
  logic              V;
  logic [OFF_W-1:0]  offset;
  logic              jr;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] tgt;
  logic              halt;
  logic [ADDR_W-1:0] PC;
  logic              taken;
  logic              halted;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_err;

  modport master (
    output stall, branch, cond, Z, N, V, offset, jr, call, ret, tgt, halt,
    input  PC, taken, halted, ras_full, ras_empty, ras_err
  );

  modport slave (
    input  stall, branch, cond, Z, N, V, offset, jr, call, ret, tgt, halt,
    output PC, taken, halted, ras_full, ras_empty, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, conditional PC-relative branches,
// register jumps, call/return through a small return-address stack, and a sticky halt.
module pc_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 9,
  parameter int STEP      = 2,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  pc_sequencer_if.slave      bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                taken_q, taken_d;
  logic                err_q, err_d;
  logic                push_en;
  logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0]   seq_pc;
  logic [ADDR_W-1:0]   br_pc;
  logic [ADDR_W-1:0]   off_ext;
  logic [ADDR_W-1:0]   top_pc;
  logic                cond_true;
  logic                stack_empty;
  logic                stack_full;

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CNT_W'(RAS_DEPTH));

  // Offset counts instruction words; shift by one to get a byte displacement.
  assign off_ext = {{(ADDR_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
  assign seq_pc  = pc_q + ADDR_W'(STEP);
  assign br_pc   = seq_pc + (off_ext << 1);
  assign top_pc  = ras_q[PTR_W'(count_q - CNT_W'(1))];

  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'b000: cond_true = ~bus.Z;
      3'b001: cond_true = bus.Z;
      3'b010: cond_true = ~bus.Z & ~bus.N;
      3'b011: cond_true = bus.N;
      3'b100: cond_true = bus.Z | ~bus.N;
      3'b101: cond_true = bus.N | bus.Z;
      3'b110: cond_true = bus.V;
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    taken_d = 1'b0;
    err_d   = 1'b0;
    push_en = 1'b0;
    if (state_q == HALTED || bus.stall) begin
      // hold everything; taken/err fall back to 0
    end else if (bus.halt) begin
      state_d = HALTED;
    end else if (bus.ret) begin
      if (!stack_empty) begin
        pc_d    = top_pc;
        count_d = count_q - CNT_W'(1);
        taken_d = 1'b1;
      end else begin
        pc_d  = seq_pc;
        err_d = 1'b1;
      end
    end else if (bus.call) begin
      pc_d    = bus.tgt;
      taken_d = 1'b1;
      if (!stack_full) begin
        push_en = 1'b1;
        count_d = count_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.jr) begin
      pc_d    = bus.tgt;
      taken_d = 1'b1;
    end else if (bus.branch && cond_true) begin
      pc_d    = br_pc;
      taken_d = 1'b1;
    end else begin
      pc_d = seq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= ADDR_W'(RESET_VEC);
      count_q <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      if (push_en) begin
        ras_q[PTR_W'(count_q)] <= seq_pc;
      end
    end
  end

  assign bus.PC        = pc_q;
  assign bus.taken     = taken_q;
  assign bus.halted    = (state_q == HALTED);
  assign bus.ras_full  = stack_full;
  assign bus.ras_empty = stack_empty;
  assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scripted sequences plus a table sweep of
// every condition code against every flag combination.
module tb_pc_sequencer;
  logic clk;
  logic rst;

  pc_sequencer_if #(.ADDR_W(16), .OFF_W(9)) bus ();

  pc_sequencer #(
    .ADDR_W(16), .OFF_W(9), .STEP(2), .RESET_VEC(0), .RAS_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        taken;
    logic        halted;
    logic        err;
    logic        full;
    logic        empty;
  } exp_t;

  typedef struct {
    logic [2:0] cond;
    logic       z;
    logic       n;
    logic       v;
    int         off;
    logic       exp_taken;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.branch = 0; bus.cond = 0; bus.Z = 0; bus.N = 0; bus.V = 0;
    bus.offset = 0; bus.jr = 0; bus.call = 0; bus.ret = 0; bus.tgt = 0; bus.halt = 0;
  endtask

  // Inputs are set by the caller; one clock is applied and the outcome compared.
  task automatic step(input string nm, input logic [15:0] pc, input logic tk,
                      input logic hl, input logic er, input logic fu, input logic em);
    exp_t e;
    e.name = nm; e.pc = pc; e.taken = tk; e.halted = hl; e.err = er; e.full = fu; e.empty = em;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".pc"},     32'(bus.PC),        32'(e.pc));
    chk({e.name, ".taken"},  32'(bus.taken),     32'(e.taken));
    chk({e.name, ".halted"}, 32'(bus.halted),    32'(e.halted));
    chk({e.name, ".err"},    32'(bus.ras_err),   32'(e.err));
    chk({e.name, ".full"},   32'(bus.ras_full),  32'(e.full));
    chk({e.name, ".empty"},  32'(bus.ras_empty), 32'(e.empty));
    $display("step %-12s PC=%04h taken=%0b halted=%0b err=%0b full=%0b empty=%0b",
             nm, bus.PC, bus.taken, bus.halted, bus.ras_err, bus.ras_full, bus.ras_empty);
    clear_inputs();
  endtask

  // Truth masks per condition code, indexed by {Z,N,V}.
  logic [7:0] cond_mask [8];
  vec_t       vecs [64];
  logic [15:0] p;

  initial begin
    cond_mask[0] = 8'h0F; cond_mask[1] = 8'hF0; cond_mask[2] = 8'h03; cond_mask[3] = 8'hCC;
    cond_mask[4] = 8'hF3; cond_mask[5] = 8'hFC; cond_mask[6] = 8'hAA; cond_mask[7] = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] iv;
      logic [7:0] m;
      iv = 6'(i);
      m  = cond_mask[iv[5:3]];
      vecs[i].cond      = iv[5:3];
      vecs[i].z         = iv[2];
      vecs[i].n         = iv[1];
      vecs[i].v         = iv[0];
      vecs[i].off       = i - 32;
      vecs[i].exp_taken = m[iv[2:0]];
    end

    clear_inputs();
    rst = 1'b1;
    step("rst0", 16'h0000, 0, 0, 0, 0, 1);
    bus.halt = 1; bus.stall = 1;
    step("rst1", 16'h0000, 0, 0, 0, 0, 1);
    rst = 1'b0;
    step("idle1", 16'h0002, 0, 0, 0, 0, 1);
    step("idle2", 16'h0004, 0, 0, 0, 0, 1);
    step("idle3", 16'h0006, 0, 0, 0, 0, 1);

    bus.jr = 1; bus.tgt = 16'h0010;
    step("jr10", 16'h0010, 1, 0, 0, 0, 1);
    bus.branch = 1; bus.cond = 3'b001; bus.Z = 1; bus.offset = 9'h1FD;
    step("br_z1", 16'h000C, 1, 0, 0, 0, 1);
    bus.jr = 1; bus.tgt = 16'h0010;
    step("jr10b", 16'h0010, 1, 0, 0, 0, 1);
    bus.branch = 1; bus.cond = 3'b001; bus.Z = 0; bus.offset = 9'h1FD;
    step("br_z0", 16'h0012, 0, 0, 0, 0, 1);

    p = 16'h0012;
    for (int i = 0; i < 64; i++) begin
      bus.branch = 1; bus.cond = vecs[i].cond;
      bus.Z = vecs[i].z; bus.N = vecs[i].n; bus.V = vecs[i].v;
      bus.offset = 9'(vecs[i].off);
      if (vecs[i].exp_taken) p = 16'(int'(p) + 2 + vecs[i].off * 2);
      else                   p = p + 16'd2;
      step($sformatf("sw_c%0d_f%0d", vecs[i].cond, i % 8), p, vecs[i].exp_taken, 0, 0, 0, 1);
    end

    bus.jr = 1; bus.tgt = 16'h0100;
    step("jr100", 16'h0100, 1, 0, 0, 0, 1);
    bus.call = 1; bus.tgt = 16'h0200;
    step("call200", 16'h0200, 1, 0, 0, 0, 0);
    bus.ret = 1;
    step("ret1", 16'h0102, 1, 0, 0, 0, 1);
    bus.ret = 1;
    step("ret_uf", 16'h0104, 0, 0, 1, 0, 1);
    step("err_clr", 16'h0106, 0, 0, 0, 0, 1);

    bus.call = 1; bus.tgt = 16'h1000; step("ncall1", 16'h1000, 1, 0, 0, 0, 0);
    bus.call = 1; bus.tgt = 16'h2000; step("ncall2", 16'h2000, 1, 0, 0, 0, 0);
    bus.call = 1; bus.tgt = 16'h3000; step("ncall3", 16'h3000, 1, 0, 0, 0, 0);
    bus.call = 1; bus.tgt = 16'h4000; step("ncall4", 16'h4000, 1, 0, 0, 1, 0);
    bus.call = 1; bus.tgt = 16'h5000; step("ncall5", 16'h5000, 1, 0, 1, 1, 0);
    bus.ret = 1; step("nret1", 16'h3002, 1, 0, 0, 0, 0);
    bus.ret = 1; step("nret2", 16'h2002, 1, 0, 0, 0, 0);
    bus.ret = 1; step("nret3", 16'h1002, 1, 0, 0, 0, 0);
    bus.ret = 1; step("nret4", 16'h0108, 1, 0, 0, 0, 1);
    bus.ret = 1; step("nret5", 16'h010A, 0, 0, 1, 0, 1);

    bus.ret = 1; bus.call = 1; bus.jr = 1; bus.tgt = 16'h0300;
    step("pri_retuf", 16'h010C, 0, 0, 1, 0, 1);
    bus.call = 1; bus.jr = 1; bus.branch = 1; bus.cond = 3'b111; bus.tgt = 16'h0400;
    step("pri_call", 16'h0400, 1, 0, 0, 0, 0);
    bus.stall = 1; bus.ret = 1; bus.halt = 1;
    step("stall", 16'h0400, 0, 0, 0, 0, 0);
    bus.jr = 1; bus.branch = 1; bus.cond = 3'b111; bus.offset = 9'd40; bus.tgt = 16'h0500;
    step("pri_jr", 16'h0500, 1, 0, 0, 0, 0);
    bus.ret = 1;
    step("pri_ret", 16'h010E, 1, 0, 0, 0, 1);

    bus.jr = 1; bus.tgt = 16'hFFFE;
    step("jrFFFE", 16'hFFFE, 1, 0, 0, 0, 1);
    step("wrap", 16'h0000, 0, 0, 0, 0, 1);
    bus.halt = 1; bus.stall = 1;
    step("halt_stl", 16'h0000, 0, 0, 0, 0, 1);
    bus.call = 1; bus.tgt = 16'h0800;
    step("call800", 16'h0800, 1, 0, 0, 0, 0);
    bus.halt = 1; bus.jr = 1; bus.tgt = 16'h0900;
    step("halt", 16'h0800, 0, 1, 0, 0, 0);
    bus.jr = 1; bus.tgt = 16'h0700;
    step("hold1", 16'h0800, 0, 1, 0, 0, 0);
    bus.ret = 1;
    step("hold2", 16'h0800, 0, 1, 0, 0, 0);
    rst = 1'b1; bus.stall = 1;
    step("rst_halt", 16'h0000, 0, 0, 0, 0, 1);
    rst = 1'b0;
    step("post_rst", 16'h0002, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, PC and target width in bits.
REQ-002 Parameter OFF_W, default 9, signed branch offset width in instruction words.
REQ-003 Parameter STEP, default 2, sequential PC increment in bytes.
REQ-004 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-005 Parameter RAS_DEPTH, default 4, return-address stack entries, power of two, ≥2.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high: clk and rst.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 stall  input  1  hold all state this cycle.
REQ-010 branch  input  1  conditional PC-relative branch request.
REQ-011 cond  input  3  condition code for branch.
REQ-012 Z, N, V  input  1 each  ALU flags.
REQ-013 offset  input  OFF_W  signed word offset for branch.
REQ-014 jr  input  1  jump to register target.
REQ-015 call  input  1  push return address, jump to register target.
REQ-016 ret  input  1  pop return address, jump to it.
REQ-017 tgt  input  ADDR_W  register target for jr/call.
REQ-018 halt  input  1  enter HALTED.
REQ-019 PC  output  ADDR_W  current program counter (registered).
REQ-020 taken  output  1  registered; previous update was a redirect.
REQ-021 halted  output  1  registered; state is HALTED.
REQ-022 ras_full, ras_empty  output  1 each  stack occupancy flags.
REQ-023 ras_err  output  1  registered one-cycle pulse on stack overflow/underflow.

Function
REQ-024 States RUN and HALTED; RUN->HALTED on halt when not stalled; HALTED exits only via rst.
REQ-025 All PC updates SHALL take effect at the next rising clk edge (latency 1); PC is never combinationally driven from inputs.
REQ-026 seq = PC + STEP; br = PC + STEP + (sign-extended offset << 1); all sums modulo 2^ADDR_W (wrap, no flag).
REQ-027 cond decode: 000 ~Z; 001 Z; 010 ~Z&~N; 011 N; 100 Z|~N; 101 N|Z; 110 V; 111 always true.
REQ-028 Per-cycle priority: rst > HALTED hold > stall > halt > ret > call > jr > branch > sequential.
REQ-029 HALTED or stall: PC, stack, state held; taken and ras_err driven 0 next cycle.
REQ-030 halt accepted: PC held (not incremented), halted=1 next cycle, taken=0.
REQ-031 ret, stack non-empty: PC <= top entry, pop, taken=1.
REQ-032 ret, stack empty: PC <= seq, no pop, ras_err=1, taken=0.
REQ-033 call, stack not full: push seq, PC <= tgt, taken=1.
REQ-034 call, stack full: PC <= tgt, push dropped, stack unchanged, ras_err=1, taken=1.
REQ-035 jr: PC <= tgt, taken=1.
REQ-036 branch with cond true: PC <= br, taken=1; cond false: PC <= seq, taken=0.
REQ-037 No request: PC <= seq, taken=0.
REQ-038 ras_full = (count == RAS_DEPTH); ras_empty = (count == 0); count is registered, width clog2(RAS_DEPTH)+1.
REQ-039 Lower-priority simultaneous requests SHALL be ignored, with no side effects on stack or flags.

Reset
REQ-040 On rst: PC=RESET_VEC, state RUN, stack count 0, taken=0, halted=0, ras_err=0, ras_empty=1, ras_full=0.
REQ-041 rst SHALL override stall, halt, and HALTED in the same cycle; stack contents are discarded.

Verification
REQ-042 rst 2 cycles, release, idle 3 cycles -> PC 0, 2, 4, 6; taken=0.
REQ-043 At PC=0x0010, branch cond=001, Z=1, offset=-3 -> PC=0x000C, taken=1; same with Z=0 -> PC=0x0012, taken=0.
REQ-044 Sweep all 8 cond codes against all 8 Z/N/V combinations -> taken matches REQ-027 table.
REQ-045 At PC=0x0100, call tgt=0x0200; at 0x0200, ret -> PC=0x0102, ras_empty=1; a further ret -> PC=0x0104, ras_err pulses 1 cycle.
REQ-046 Five nested calls with RAS_DEPTH=4 -> fifth sets ras_err, ras_full stays 1, four rets return innermost-first, fifth ret underflows.
REQ-047 PC=0xFFFE idle -> PC=0x0000; halt with stall=1 -> ignored; halt alone -> PC frozen, halted=1 until rst, then PC=RESET_VEC.
